hwag_sync_ctrl: RTL
===================

// Module: hwag_sync_ctrl
// PURPOSE
//  Crank/cam synchronisation sequencer that drives hwag_core.
//  Consumes per-tooth capture strobes and periods from the VR capture path and finds the missing-tooth gap.
//  Verifies a full revolution of tooth counts, then issues hwag_start and tracks the 720-degree cycle phase from the cam input.
//  Drops sync and reports errors on tooth-count mismatch, stall or disable.
// PARAMETERS
//  TEETH_TOTAL  60   nominal teeth per revolution, missing teeth included
//  TEETH_MISS   2    missing teeth; real teeth per rev = TEETH_TOTAL-TEETH_MISS (58)
//  PER_W        24   width of the period and stall counters
//  STALL_TICKS  24'hFFFFF  clocks with no cap_stb before a stall is declared
//  CAM_TOOTH    30   tooth number at which cam_lvl is sampled
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-low (rst==0 resets on clk rise)
//  en          in   1      enable; 0 forces IDLE
//  cap_stb     in   1      one-cycle strobe per valid tooth edge
//  cap_period  in   PER_W  clocks since previous tooth edge; valid with cap_stb
//  cam_lvl     in   1      synchronised cam sensor level
//  sync_state  out  3      0 IDLE, 1 WAIT_REF, 2 SEARCH, 3 VERIFY, 4 SYNC
//  synced      out  1      1 only in SYNC
//  hwag_start  out  1      one-cycle pulse on entry to SYNC
//  hwag_stop   out  1      one-cycle pulse on any exit from SYNC
//  tooth_num   out  6      current tooth index; gap edge = 0; valid in VERIFY/SYNC
//  gap_stb     out  1      one-cycle pulse on each detected gap edge
//  cyc_phase   out  1      0 = first revolution of the 720-degree cycle, 1 = second
//  phase_ok    out  1      cyc_phase is cam-confirmed
//  err_stb     out  1      one-cycle pulse on sync loss (count error or stall)
//  cam_err     out  1      one-cycle pulse on cam/phase mismatch
//  err_cnt     out  8      saturating count of err_stb pulses
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; prev_period 0; stall counter 0.
//  All outputs are registered and update on the clk edge after the cap_stb cycle (latency 1).
//  Gap test: gap = ({1'b0,cap_period} > {prev_period,1'b0}), i.e. more than 2x the previous period, compared in PER_W+1 bits.
//   prev_period <= cap_period on every cap_stb.
//  IDLE: leaves to WAIT_REF when en=1.
//   en=0 in any state returns to IDLE next cycle, clears phase_ok and tooth_num, and overrides cap_stb.
//   Leaving SYNC this way pulses hwag_stop but not err_stb.
//  WAIT_REF: first cap_stb only loads prev_period, then go to SEARCH.
//  SEARCH: on gap, tooth_num<=0, gap_stb, go to VERIFY; non-gap edges are ignored.
//  VERIFY: each non-gap edge increments tooth_num.
//   Gap with tooth_num==57 -> SYNC, hwag_start, tooth_num<=0.
//   Gap at any other count, or a non-gap edge when tooth_num==57 -> err_stb, SEARCH.
//  SYNC: same counting rules; gap at 57 wraps tooth_num to 0 and toggles cyc_phase.
//   A count violation -> err_stb + hwag_stop, SEARCH; the offending gap edge is re-used as the VERIFY start (tooth_num<=0).
//  Cam: on the edge giving tooth_num==CAM_TOOTH in SYNC, expected = (cam_lvl==1) ? 0 : 1.
//   If !phase_ok: cyc_phase<=expected, phase_ok<=1.
//   If phase_ok and cyc_phase!=expected: cam_err, cyc_phase<=expected.
//   Any exit from SYNC clears phase_ok.
//  Stall: counter clears on cap_stb and otherwise increments, saturating at all-ones.
//   Reaching STALL_TICKS in VERIFY/SYNC -> err_stb (+hwag_stop if in SYNC), go to WAIT_REF.
//   Stall in SEARCH -> WAIT_REF without err_stb.
//   cap_stb in the same cycle as the stall threshold: the edge wins, no stall.
//  err_cnt saturates at 8'hFF; cleared only by reset.
//  Reset asserted mid-operation: all state returns to reset values on that edge; no hwag_stop pulse.
// TESTING
//  1. 60-2 pattern, period 128, gap 384, cam high at teeth 4..54 on alternate revs -> VERIFY after the first gap; hwag_start at the 2nd gap; tooth_num 0..57 wraps; phase_ok=1 at tooth 30.
//  2. Synced, then one tooth removed (gap arrives at tooth_num 56) -> err_stb, hwag_stop, err_cnt=1, state VERIFY with tooth_num=0.
//  3. Synced, then cap_stb stopped for STALL_TICKS clocks -> err_stb, hwag_stop, state WAIT_REF; edges resume -> resync after 2 gaps.
//  4. Synced with phase_ok, then cam inverted for one rev -> cam_err at tooth 30, cyc_phase corrected, synced stays 1.
//  5. en dropped during SYNC, coincident with cap_stb -> IDLE next cycle, hwag_stop=1, err_stb=0, tooth_num=0.
//  6. Accelerating wheel (period decreasing by 1 per rev, as in the scnt_top stimulus) -> no false gaps; err_cnt stays 0 over 100 revs.

Source files
------------

// File: rtl/hwag_sync_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hwag_sync_ctrl_if : tooth-capture inputs and sync status outputs of the
//                     crank/cam synchronisation sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
interface hwag_sync_ctrl_if #(
   parameter int PER_W = 24
);
   logic             en;
   logic             cap_stb;
   logic [PER_W-1:0] cap_period;
   logic             cam_lvl;

   logic [2:0]       sync_state;
   logic             synced;
   logic             hwag_start;
   logic             hwag_stop;
   logic [5:0]       tooth_num;
   logic             gap_stb;
   logic             cyc_phase;
   logic             phase_ok;
   logic             err_stb;
   logic             cam_err;
   logic [7:0]       err_cnt;

   modport master (
      output en, cap_stb, cap_period, cam_lvl,
      input  sync_state, synced, hwag_start, hwag_stop, tooth_num, gap_stb,
             cyc_phase, phase_ok, err_stb, cam_err, err_cnt
   );

   modport slave (
      input  en, cap_stb, cap_period, cam_lvl,
      output sync_state, synced, hwag_start, hwag_stop, tooth_num, gap_stb,
             cyc_phase, phase_ok, err_stb, cam_err, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hwag_sync_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hwag_sync_ctrl : missing-tooth gap search, revolution verify and 720-degree
//                  phase tracking that gates hwag_core via hwag_start/stop
// Revision 1.0
// ----------------------------------------------------------------------------
module hwag_sync_ctrl #(
   parameter int               TEETH_TOTAL = 60,
   parameter int               TEETH_MISS  = 2,
   parameter int               PER_W       = 24,
   parameter logic [PER_W-1:0] STALL_TICKS = 'hFFFFF,
   parameter int               CAM_TOOTH   = 30
) (
   input wire logic          clk,
   input wire logic          rst,
   hwag_sync_ctrl_if.slave   bus
);
   localparam logic [5:0] C_LAST_TOOTH = 6'(TEETH_TOTAL - TEETH_MISS - 1);
   localparam logic [5:0] C_CAM_TOOTH  = 6'(CAM_TOOTH);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_REF = 3'd1,
      ST_SEARCH   = 3'd2,
      ST_VERIFY   = 3'd3,
      ST_SYNC     = 3'd4
   } state_t;

   state_t           r_state,   w_state;
   logic [PER_W-1:0] r_prev_period;
   logic [PER_W-1:0] r_stall_cnt;
   logic [5:0]       r_tooth,   w_tooth;
   logic             r_phase,   w_phase;
   logic             r_phase_ok, w_phase_ok;
   logic [7:0]       r_err_cnt, w_err_cnt;
   logic             r_start,   w_start;
   logic             r_stop,    w_stop;
   logic             r_gap_stb, w_gap_stb;
   logic             r_err,     w_err;
   logic             r_cam_err, w_cam_err;

   logic             w_gap;
   logic             w_stall;
   logic             w_at_last;
   logic             w_keep_sync;
   logic             w_cam_exp;

   // A gap is an interval longer than twice the previous one.
   assign w_gap     = {1'b0, bus.cap_period} > {r_prev_period, 1'b0};
   assign w_stall   = !bus.cap_stb && (r_stall_cnt >= STALL_TICKS);
   assign w_at_last = (r_tooth == C_LAST_TOOTH);
   assign w_cam_exp = ~bus.cam_lvl;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_prev_period <= '0;
         r_stall_cnt   <= '0;
         r_tooth       <= '0;
         r_phase       <= 1'b0;
         r_phase_ok    <= 1'b0;
         r_err_cnt     <= '0;
         r_start       <= 1'b0;
         r_stop        <= 1'b0;
         r_gap_stb     <= 1'b0;
         r_err         <= 1'b0;
         r_cam_err     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_tooth    <= w_tooth;
         r_phase    <= w_phase;
         r_phase_ok <= w_phase_ok;
         r_err_cnt  <= w_err_cnt;
         r_start    <= w_start;
         r_stop     <= w_stop;
         r_gap_stb  <= w_gap_stb;
         r_err      <= w_err;
         r_cam_err  <= w_cam_err;
         if (bus.cap_stb) begin
            r_prev_period <= bus.cap_period;
            r_stall_cnt   <= '0;
         end else if (r_stall_cnt != {PER_W{1'b1}}) begin
            r_stall_cnt   <= r_stall_cnt + PER_W'(1);
         end
      end
   end

   always_comb begin
      w_state     = r_state;
      w_tooth     = r_tooth;
      w_phase     = r_phase;
      w_phase_ok  = r_phase_ok;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_gap_stb   = 1'b0;
      w_err       = 1'b0;
      w_cam_err   = 1'b0;
      w_keep_sync = 1'b0;

      if (!bus.en) begin
         w_state    = ST_IDLE;
         w_tooth    = '0;
         w_phase_ok = 1'b0;
         w_stop     = (r_state == ST_SYNC);
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state = ST_WAIT_REF;
            end

            ST_WAIT_REF: begin
               if (bus.cap_stb) begin
                  w_state = ST_SEARCH;
               end
            end

            ST_SEARCH: begin
               if (bus.cap_stb) begin
                  if (w_gap) begin
                     w_tooth   = '0;
                     w_gap_stb = 1'b1;
                     w_state   = ST_VERIFY;
                  end
               end else if (w_stall) begin
                  w_state = ST_WAIT_REF;
               end
            end

            ST_VERIFY: begin
               if (bus.cap_stb) begin
                  if (w_gap) begin
                     w_gap_stb = 1'b1;
                     w_tooth   = '0;
                     if (w_at_last) begin
                        w_state = ST_SYNC;
                        w_start = 1'b1;
                     end else begin
                        w_err   = 1'b1;
                        w_state = ST_SEARCH;
                     end
                  end else if (w_at_last) begin
                     w_err   = 1'b1;
                     w_state = ST_SEARCH;
                  end else begin
                     w_tooth = r_tooth + 6'd1;
                  end
               end else if (w_stall) begin
                  w_err   = 1'b1;
                  w_state = ST_WAIT_REF;
               end
            end

            ST_SYNC: begin
               if (bus.cap_stb) begin
                  if (w_gap) begin
                     w_gap_stb = 1'b1;
                     w_tooth   = '0;
                     if (w_at_last) begin
                        w_phase     = ~r_phase;
                        w_keep_sync = 1'b1;
                     end else begin
                        // The early gap itself starts a fresh verify pass.
                        w_err      = 1'b1;
                        w_stop     = 1'b1;
                        w_phase_ok = 1'b0;
                        w_state    = ST_VERIFY;
                     end
                  end else if (w_at_last) begin
                     w_err      = 1'b1;
                     w_stop     = 1'b1;
                     w_phase_ok = 1'b0;
                     w_state    = ST_SEARCH;
                  end else begin
                     w_tooth     = r_tooth + 6'd1;
                     w_keep_sync = 1'b1;
                  end
               end else if (w_stall) begin
                  w_err      = 1'b1;
                  w_stop     = 1'b1;
                  w_phase_ok = 1'b0;
                  w_state    = ST_WAIT_REF;
               end
            end

            default: begin
               w_state = ST_IDLE;
            end
         endcase
      end

      // Cam level at the reference tooth decides which revolution this is.
      if (w_keep_sync && (w_tooth == C_CAM_TOOTH)) begin
         if (!r_phase_ok) begin
            w_phase    = w_cam_exp;
            w_phase_ok = 1'b1;
         end else if (w_phase != w_cam_exp) begin
            w_cam_err = 1'b1;
            w_phase   = w_cam_exp;
         end
      end

      w_err_cnt = r_err_cnt;
      if (w_err && (r_err_cnt != 8'hFF)) begin
         w_err_cnt = r_err_cnt + 8'd1;
      end
   end

   assign bus.sync_state = r_state;
   assign bus.synced     = (r_state == ST_SYNC);
   assign bus.hwag_start = r_start;
   assign bus.hwag_stop  = r_stop;
   assign bus.tooth_num  = r_tooth;
   assign bus.gap_stb    = r_gap_stb;
   assign bus.cyc_phase  = r_phase;
   assign bus.phase_ok   = r_phase_ok;
   assign bus.err_stb    = r_err;
   assign bus.cam_err    = r_cam_err;
   assign bus.err_cnt    = r_err_cnt;
endmodule
`default_nettype wire
